// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES encryption datapath: accepts one block,
// launches NUM_ROUNDS registered rounds, then holds the ciphertext until it is taken.
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned DP_LAT     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       st_load,
  output logic       rnd_go,
  output logic       st_capture,
  output logic [3:0] rnd_cnt,
  output logic       mc_bypass,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_e;

  localparam logic [3:0] LastRnd = 4'(NUM_ROUNDS);
  localparam logic [3:0] LatMax  = 4'(DP_LAT);

  state_e     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [3:0] wait_q, wait_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    wait_d     = wait_q;
    in_ready   = 1'b0;
    st_load    = 1'b0;
    rnd_go     = 1'b0;
    st_capture = 1'b0;
    out_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_load = 1'b1;
          rnd_d   = 4'd1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        rnd_go  = 1'b1;
        wait_d  = 4'd1;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == LatMax) begin
          st_capture = 1'b1;
          if (rnd_q == LastRnd) begin
            state_d = DONE;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            state_d = LAUNCH;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rnd_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    mc_bypass = ((state_q == LAUNCH) || (state_q == WAIT)) && (rnd_q == LastRnd);

    // Abort discards any block in flight, including a finished one in DONE.
    if (flush) begin
      state_d    = IDLE;
      rnd_d      = 4'd0;
      wait_d     = 4'd0;
      in_ready   = 1'b0;
      st_load    = 1'b0;
      rnd_go     = 1'b0;
      st_capture = 1'b0;
      out_valid  = 1'b0;
    end

    // While reset is held the outputs show the idle values regardless of inputs.
    if (!rst_n) begin
      in_ready   = 1'b1;
      st_load    = 1'b0;
      rnd_go     = 1'b0;
      st_capture = 1'b0;
      out_valid  = 1'b0;
      mc_bypass  = 1'b0;
    end
  end

  assign rnd_cnt = rnd_q;
  assign busy    = (state_q != IDLE);

endmodule
